// File: rtl/dmem_ctrl.sv
// Byte-addressed little-endian data memory controller: byte/half/word loads and stores
// over a DEPTH x 32-bit array, with an optional zero-fill sweep after reset.
`timescale 1ns/1ps
module dmem_ctrl #(
  parameter int unsigned DEPTH          = 256,
  parameter int unsigned ADDR_W         = 32,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              wen,
  input  logic [ADDR_W-1:0] add,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [31:0]       data_in,
  output logic              ready,
  output logic [31:0]       data_out,
  output logic              rvalid,
  output logic              err
);
  localparam int unsigned     IDX_W      = $clog2(DEPTH);
  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(4 * DEPTH);
  localparam logic [1:0]      SZ_BYTE    = 2'b00;
  localparam logic [1:0]      SZ_HALF    = 2'b01;
  localparam logic [1:0]      SZ_WORD    = 2'b10;

  typedef enum logic {CLEAR, READY} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] clr_cnt;
  logic [31:0]      mem [DEPTH];

  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic             accept;
  logic             illegal;
  logic [3:0]       be;
  logic [31:0]      wdata;
  logic [31:0]      rword;
  logic [31:0]      rshift;
  logic [31:0]      rdata;

  assign idx    = add[IDX_W+1:2];
  assign lane   = add[1:0];
  // Gated by rst so nothing is accepted while reset is held, whatever the reset state.
  assign ready  = (state == READY) && !rst;
  assign accept = req && ready;

  // Alignment, size and range legality of the presented request
  always_comb begin
    illegal = 1'b0;
    case (size)
      SZ_BYTE: illegal = 1'b0;
      SZ_HALF: illegal = lane[0];
      SZ_WORD: illegal = (lane != 2'b00);
      default: illegal = 1'b1;
    endcase
    if ({1'b0, add} >= ADDR_LIMIT) illegal = 1'b1;
  end

  // Store lane enables and replicated write data
  always_comb begin
    be    = 4'b0000;
    wdata = data_in;
    case (size)
      SZ_BYTE: begin
        be    = 4'b0001 << lane;
        wdata = {4{data_in[7:0]}};
      end
      SZ_HALF: begin
        be    = 4'b0011 << lane;
        wdata = {2{data_in[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = data_in;
      end
    endcase
  end

  // Load lane extraction and extension
  assign rword  = mem[idx];
  assign rshift = rword >> {lane, 3'b000};

  always_comb begin
    rdata = rshift;
    case (size)
      SZ_BYTE: rdata = {{24{sign_ext & rshift[7]}}, rshift[7:0]};
      SZ_HALF: rdata = {{16{sign_ext & rshift[15]}}, rshift[15:0]};
      default: rdata = rshift;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= CLEAR_ON_RESET ? CLEAR : READY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (clr_cnt == IDX_W'(DEPTH - 1)) state_nxt = READY;
      default: state_nxt = READY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                 clr_cnt <= '0;
    else if (state == CLEAR) clr_cnt <= clr_cnt + IDX_W'(1);
  end

  // Array has no reset: it is only zeroed by the clear sweep
  always_ff @(posedge clk) begin
    if (!rst && state == CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (accept && wen && !illegal) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
      rvalid   <= 1'b0;
      err      <= 1'b0;
    end else begin
      rvalid <= accept && !wen && !illegal;
      err    <= accept && illegal;
      if (accept && !wen && !illegal) data_out <= rdata;
    end
  end

endmodule
